dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, 256, number of 32-bit words in storage (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; reset rst, asynchronous, active-high; clock clk.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port req_be  input  4  byte-lane write enables; bit i controls bits 8i+7:8i.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errored accesses.
REQ-014 SHALL have port rsp_err  output  1  access rejected.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-017 SHALL accept a request on a rising edge with req_valid && req_ready, latching we/addr/wdata/be.
REQ-018 SHALL, on acceptance, go to WAIT with a down-counter loaded to WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES == 0.
REQ-019 SHALL, in WAIT, decrement the counter each edge and go to RESP on the edge where the counter is 0; rsp_valid first high exactly WAIT_CYCLES edges after the accept edge (0 = the accept edge itself).
REQ-020 SHALL commit a write to storage on the accept edge, updating only lanes with req_be[i] = 1; req_be = 4'b0000 is a no-op write that still produces a normal response.
REQ-021 SHALL capture read data into rsp_rdata on the edge entering RESP; reads ignore req_be and return the full word.
REQ-022 SHALL flag out-of-range access (req_addr[31:2] >= DEPTH_WORDS): rsp_err = 1, rsp_rdata = 0, write suppressed.
REQ-023 SHALL hold rsp_valid, rsp_rdata, and rsp_err stable in RESP until rsp_ready is high on an edge, then return to IDLE.
REQ-024 SHALL NOT accept a new request in WAIT or RESP; req_valid there is ignored; minimum request-to-request spacing is WAIT_CYCLES+2 edges.
REQ-025 SHALL, when rsp_ready is already high on entry to RESP, complete the handshake on the next edge (single-cycle rsp_valid pulse).

Reset
REQ-026 SHALL, while rst is high, force state IDLE, counter 0, rsp_rdata 0, rsp_err 0; hence rsp_valid 0, busy 0, req_ready 1.
REQ-027 SHALL abandon an in-flight request on reset mid-operation with no response issued; a write already committed on its accept edge remains.
REQ-028 SHALL NOT reset storage contents; the array is uninitialised after power-up.

Configuration
REQ-029 SHALL compile a misalignment check when DMEM_MISALIGN_CHECK_EN is defined: req_addr[1:0] != 0 gives rsp_err = 1, rsp_rdata = 0, and no write.
REQ-030 SHALL, without DMEM_MISALIGN_CHECK_EN, ignore req_addr[1:0] entirely (access the word at req_addr[31:2], never error on alignment).

Structure
REQ-031 SHALL place the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the byte-lane count (4), and the word width (32) in shared package dmem_pkg.
REQ-032 SHALL instantiate one sub-module dmem_array (DEPTH_WORDS x 32 storage, byte-enable synchronous write, combinational read); the FSM, counter, and error logic stay in dmem_responder.

Verification
REQ-033 SHALL cover write/read with WAIT_CYCLES=2: write addr 0x10, data 0xDEADBEEF, be 4'hF, then read 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid rising 2 edges after each accept.
REQ-034 SHALL cover partial write: after 0xDEADBEEF at 0x10, write 0x000000AA with be 4'b0001, then read -> 0xDEADBEAA.
REQ-035 SHALL cover backpressure: hold rsp_ready 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0, a second req_valid not accepted.
REQ-036 SHALL cover range error with DEPTH_WORDS=256: write to 0x400 -> rsp_err 1, rsp_rdata 0, word 0 unchanged on readback.
REQ-037 SHALL cover misalignment: read 0x12 -> rsp_err 1 with DMEM_MISALIGN_CHECK_EN defined, and the contents of 0x10 with rsp_err 0 without it.
REQ-038 SHALL cover reset mid-WAIT and WAIT_CYCLES=0: reset during WAIT -> rsp_valid never asserts and req_ready 1 after reset; with WAIT_CYCLES=0, rsp_valid high right after the accept edge.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
// Holds the FSM state encoding, lane count and word width.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int BYTE_W = WORD_W / LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator (master) and the data-memory responder (slave).
// Uses valid/ready on both channels; busy is a status output from the responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage with per-byte synchronous write and combinational read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && be[i]) begin
        mem[addr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: writes commit on the accept edge, response after WAIT_CYCLES edges, held until rsp_ready.
// Optional alignment checking is compiled in with DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              enter_resp;
  logic              accept;

  logic [AW-1:0]     idx_q;
  logic              we_q;
  logic              err_q;

  logic [AW-1:0]     idx_live;
  logic              range_err_live;
  logic              err_live;

  logic [AW-1:0]     sel_idx;
  logic              sel_we;
  logic              sel_err;
  logic [WORD_W-1:0] rd_word;

  assign accept         = bus.req_valid && (state == IDLE);
  assign idx_live       = bus.req_addr[2 +: AW];
  assign range_err_live = |(bus.req_addr[WORD_W-1:2] >> AW);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign err_live = range_err_live || (bus.req_addr[1:0] != 2'b00);
`else
  logic align_unused;
  assign align_unused = ^bus.req_addr[1:0];
  assign err_live     = range_err_live;
`endif

  // With zero wait states RESP is entered on the accept edge, so the live request must feed the read.
  assign sel_idx = (state == IDLE) ? idx_live    : idx_q;
  assign sel_we  = (state == IDLE) ? bus.req_we  : we_q;
  assign sel_err = (state == IDLE) ? err_live    : err_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (accept && bus.req_we && !err_live),
    .addr  (sel_idx),
    .wdata (bus.req_wdata),
    .be    (bus.req_be),
    .rdata (rd_word)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      idx_q         <= '0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q <= idx_live;
        we_q  <= bus.req_we;
        err_q <= err_live;
      end
      if (enter_resp) begin
        bus.rsp_err   <= sel_err;
        bus.rsp_rdata <= (sel_err || sel_we) ? '0 : rd_word;
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table on a WAIT_CYCLES=2 instance plus hand sequences for
// backpressure, reset mid-WAIT and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  dmem_responder_if bus ();
  dmem_responder_if bz ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bz)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output int lat);
    int n;
    @(negedge clk);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    if (!bus.rsp_valid) lat = -1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        seen;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h10,  32'h11223344, 4'h0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
    vecs[6]  = '{1'b1, 32'h0,   32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h0,   32'h0,        4'hF, 32'h12345678, 1'b0};
    vecs[9]  = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hC, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'hCAFEA5A5, 1'b0};
    vecs[13] = '{1'b1, 32'h20,  32'h0,        4'hF, 32'h0,        1'b0};
    vecs[14] = '{1'b1, 32'h20,  32'h11223344, 4'hA, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h11003300, 1'b0};
    vecs[16] = '{1'b0, 32'h12,  32'h0,        4'hF, MIS_EN ? 32'h0 : 32'hDEADBEAA, MIS_EN};
    vecs[17] = '{1'b1, 32'h11,  32'hFFFFFFFF, 4'hF, 32'h0,        MIS_EN};
    vecs[18] = '{1'b0, 32'h10,  32'h0,        4'hF, MIS_EN ? 32'hDEADBEAA : 32'hFFFFFFFF, 1'b0};
    vecs[19] = '{1'b0, 32'hFFFFFFFC, 32'h0,   4'hF, 32'h0,        1'b1};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_be = 4'h0; bus.rsp_ready = 1'b1;
    bz.req_valid  = 1'b0; bz.req_we  = 1'b0; bz.req_addr  = '0;
    bz.req_wdata  = '0;   bz.req_be  = 4'h0; bz.rsp_ready  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst busy",      32'(bus.busy),      32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata,      32'h0);
    chk("rst rsp_err",   32'(bus.rsp_err),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d rsp_drop", i), 32'(bus.rsp_valid), 32'd0);
    end

    // Backpressure: response held for 5 cycles while a competing request is presented.
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_be = 4'hF;
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_wdata = 32'h0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp reached_resp", 32'(bus.rsp_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d rsp_rdata", c), bus.rsp_rdata, 32'h12345678);
      chk($sformatf("bp%0d req_ready", c), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp released rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp released req_ready", 32'(bus.req_ready), 32'd1);
    txn(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    chk("bp second_req_ignored", rd, 32'h12345678);

    // Reset in WAIT: no response, but the write already committed survives.
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = 32'h55AA55AA;
    bus.req_be = 4'hF; bus.rsp_ready = 1'b1; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid busy_in_wait", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("mid no_response", 32'(seen), 32'd0);
    chk("mid req_ready", 32'(bus.req_ready), 32'd1);
    txn(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat);
    chk("mid committed_write", rd, 32'h55AA55AA);

    // Zero wait states: rsp_valid right after the accept edge.
    @(negedge clk);
    bz.req_we = 1'b1; bz.req_addr = 32'h8; bz.req_wdata = 32'hBEEF0001;
    bz.req_be = 4'hF; bz.rsp_ready = 1'b1; bz.req_valid = 1'b1;
    @(negedge clk);
    bz.req_valid = 1'b0;
    chk("w0 wr rsp_valid", 32'(bz.rsp_valid), 32'd1);
    chk("w0 wr rsp_err",   32'(bz.rsp_err),   32'd0);
    chk("w0 wr rsp_rdata", bz.rsp_rdata,      32'h0);
    @(negedge clk);
    chk("w0 pulse rsp_valid", 32'(bz.rsp_valid), 32'd0);
    chk("w0 pulse req_ready", 32'(bz.req_ready), 32'd1);
    bz.req_we = 1'b0; bz.req_valid = 1'b1;
    @(negedge clk);
    bz.req_valid = 1'b0;
    chk("w0 rd rsp_valid", 32'(bz.rsp_valid), 32'd1);
    chk("w0 rd rsp_rdata", bz.rsp_rdata,      32'hBEEF0001);
    @(negedge clk);
    bz.req_addr = 32'h40; bz.req_valid = 1'b1;
    @(negedge clk);
    bz.req_valid = 1'b0;
    chk("w0 range rsp_err",   32'(bz.rsp_err), 32'd1);
    chk("w0 range rsp_rdata", bz.rsp_rdata,    32'h0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
